cpu_run_controller: RTL and testbench

- Run/halt/single-step sequencer for the single-cycle processor.
- Sits between a debug/host command port and the datapath. Drives one cpu_enable gate that qualifies PC update, register-file write and data-memory write.
- Stops execution on host command, step-count exhaustion, PC breakpoint or a halt instruction. Keeps cycle and retired-instruction counters.

---
 rtl/cpu_run_controller.sv | 169 ++++++++++++++++
 tb/tb_cpu_run_controller.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_controller.sv
// Run/halt/single-step sequencer for the single-cycle processor.
// Gates datapath commits through cpu_enable. Stops on a host command,
// step-count exhaustion, a PC breakpoint or the halt instruction.
// Keeps cycle and retired-instruction counters for the host.
module cpu_run_controller #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned COUNT_WIDTH = 32,
  parameter logic [31:0] HALT_INSTR  = 32'h00100073,
  parameter bit          RESET_RUN   = 1'b0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [15:0]            step_count,
  input  logic                   bp_enable,
  input  logic [XLEN-1:0]        bp_address,
  input  logic [XLEN-1:0]        pc,
  input  logic [31:0]            instruction,
  output logic                   cpu_enable,
  output logic [1:0]             state,
  output logic [1:0]             halt_cause,
  output logic                   cmd_error,
  output logic [COUNT_WIDTH-1:0] cycle_count,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  typedef enum logic [1:0] {
    ST_HALTED = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_RUN   = 2'b00,
    OP_STEP  = 2'b01,
    OP_HALT  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  localparam logic [1:0] CAUSE_CMD   = 2'b00;
  localparam logic [1:0] CAUSE_STEP  = 2'b01;
  localparam logic [1:0] CAUSE_BP    = 2'b10;
  localparam logic [1:0] CAUSE_EBRK  = 2'b11;

  localparam state_t RESET_STATE = RESET_RUN ? ST_RUN : ST_HALTED;

  state_t                 state_q, state_d;
  logic [1:0]             cause_q, cause_d;
  logic                   skip_q, skip_d;
  logic [15:0]            remaining_q, remaining_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   cmd_error_q, cmd_error_d;
  logic [COUNT_WIDTH-1:0] cycle_q, cycle_d;
  logic [COUNT_WIDTH-1:0] retired_q, retired_d;

  logic        is_halt_instr;
  logic        bp_hit;
  logic        stop;
  logic        active;
  logic        cmd_fire;
  logic [15:0] step_load;

  // The current instruction is only allowed to commit when nothing asks to stop
  // on it; skip lets a resumed core step past the stop that halted it.
  always_comb begin
    is_halt_instr = (instruction == HALT_INSTR);
    bp_hit        = bp_enable && (pc == bp_address);
    stop          = (is_halt_instr || bp_hit) && !skip_q;
    active        = (state_q != ST_HALTED);
    cpu_enable    = active && !stop;
    cmd_fire      = cmd_valid && cmd_ready_q;
    step_load     = (step_count == 16'd0) ? 16'd1 : step_count;
  end

  // Next-state, halt cause, step budget and handshake; datapath stops beat
  // step completion, which beats a host HALT arriving in the same cycle.
  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    skip_d      = skip_q;
    remaining_d = remaining_q;
    cmd_error_d = 1'b0;
    cmd_ready_d = !cmd_fire;

    if (!active) begin
      if (cmd_fire) begin
        unique case (op_t'(cmd_op))
          OP_RUN: begin
            state_d = ST_RUN;
            skip_d  = 1'b1;
          end
          OP_STEP: begin
            state_d     = ST_STEP;
            remaining_d = step_load;
            skip_d      = 1'b1;
          end
          OP_HALT:  cause_d = CAUSE_CMD;
          OP_CLEAR: ;
          default:  ;
        endcase
      end
    end else begin
      if (cpu_enable) begin
        skip_d = 1'b0;
      end
      if ((state_q == ST_STEP) && cpu_enable) begin
        remaining_d = remaining_q - 16'd1;
      end
      if (cmd_fire && ((cmd_op == OP_RUN) || (cmd_op == OP_STEP))) begin
        cmd_error_d = 1'b1;
      end

      if (stop) begin
        state_d = ST_HALTED;
        cause_d = is_halt_instr ? CAUSE_EBRK : CAUSE_BP;
      end else if ((state_q == ST_STEP) && cpu_enable && (remaining_q == 16'd1)) begin
        state_d = ST_HALTED;
        cause_d = CAUSE_STEP;
      end else if (cmd_fire && (cmd_op == OP_HALT)) begin
        state_d = ST_HALTED;
        cause_d = CAUSE_CMD;
      end
    end
  end

  // Free-running wrap-around counters; a CLEAR overrides this cycle's increment.
  always_comb begin
    cycle_d   = cycle_q + COUNT_WIDTH'(active);
    retired_d = retired_q + COUNT_WIDTH'(cpu_enable);
    if (cmd_fire && (cmd_op == OP_CLEAR)) begin
      cycle_d   = '0;
      retired_d = '0;
    end
  end

  // State register; reset drops the core out of RUN at once so cpu_enable
  // falls without waiting for a clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= RESET_STATE;
      cause_q     <= CAUSE_CMD;
      skip_q      <= 1'b0;
      remaining_q <= 16'd0;
      cmd_ready_q <= 1'b1;
      cmd_error_q <= 1'b0;
      cycle_q     <= '0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      skip_q      <= skip_d;
      remaining_q <= remaining_d;
      cmd_ready_q <= cmd_ready_d;
      cmd_error_q <= cmd_error_d;
      cycle_q     <= cycle_d;
      retired_q   <= retired_d;
    end
  end

  assign state         = state_q;
  assign halt_cause    = cause_q;
  assign cmd_ready     = cmd_ready_q;
  assign cmd_error     = cmd_error_q;
  assign cycle_count   = cycle_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Testbench for cpu_run_controller: a tiny datapath (PC register plus a
// 64-word program memory) surrounds the controller, and each run is predicted
// by walking the program from the starting PC until a stop or the step budget.
module tb_cpu_run_controller;

  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam logic [1:0]  OP_RUN = 2'b00, OP_STEP = 2'b01, OP_HALT = 2'b10, OP_CLEAR = 2'b11;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] step_count;
  logic        bp_enable;
  logic [31:0] bp_address;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        cpu_enable;
  logic [1:0]  state;
  logic [1:0]  halt_cause;
  logic        cmd_error;
  logic [31:0] cycle_count;
  logic [31:0] retired_count;

  // narrow-counter copy used to observe wrap-around
  logic        w_cmd_ready, w_cpu_enable, w_cmd_error;
  logic [1:0]  w_state, w_halt_cause;
  logic [3:0]  w_cycle, w_retired;

  logic [31:0] prog [0:63];
  logic        pc_load;
  logic [31:0] pc_load_val;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  assign instruction = prog[pc[7:2]];

  // Datapath model: the PC advances only on committed cycles
  always @(posedge clock or negedge reset) begin
    if (!reset)          pc <= 32'd0;
    else if (pc_load)    pc <= pc_load_val;
    else if (cpu_enable) pc <= pc + 32'd4;
  end

  cpu_run_controller dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .step_count(step_count), .bp_enable(bp_enable),
    .bp_address(bp_address), .pc(pc), .instruction(instruction),
    .cpu_enable(cpu_enable), .state(state), .halt_cause(halt_cause),
    .cmd_error(cmd_error), .cycle_count(cycle_count), .retired_count(retired_count)
  );

  cpu_run_controller #(.COUNT_WIDTH(4)) dut_w (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(w_cmd_ready),
    .cmd_op(cmd_op), .step_count(step_count), .bp_enable(bp_enable),
    .bp_address(bp_address), .pc(pc), .instruction(instruction),
    .cpu_enable(w_cpu_enable), .state(w_state), .halt_cause(w_halt_cause),
    .cmd_error(w_cmd_error), .cycle_count(w_cycle), .retired_count(w_retired)
  );

  // ---------------- reference model ----------------
  function automatic bit stop_at(input logic [31:0] p);
    return (prog[p[7:2]] == EBREAK) || (bp_enable && (p == bp_address));
  endfunction

  // Walk the program: the first instruction always commits, later ones stop
  // the run if they match; STEP ends after max(n,1) commits.
  function automatic void predict(input logic [31:0] start_pc, input bit is_step, input int n,
                                  output int commits, output int cycles, output logic [1:0] cause);
    int lim;
    logic [31:0] p;
    lim     = (n == 0) ? 1 : n;
    p       = start_pc;
    commits = 0;
    cycles  = 0;
    cause   = 2'b00;
    for (int i = 0; i < 1000; i++) begin
      if (i > 0 && stop_at(p)) begin
        cycles = commits + 1;
        cause  = (prog[p[7:2]] == EBREAK) ? 2'b11 : 2'b10;
        return;
      end
      commits++;
      p += 32'd4;
      if (is_step && commits == lim) begin
        cycles = commits;
        cause  = 2'b01;
        return;
      end
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic fill_prog();
    for (int i = 0; i < 64; i++) prog[i] = NOP;
    prog[63] = EBREAK;
  endtask

  task automatic load_pc(input logic [31:0] a);
    pc_load = 1'b1;
    pc_load_val = a;
    @(negedge clock);
    pc_load = 1'b0;
  endtask

  // Present one command once the controller is ready; returns on the
  // falling edge after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [15:0] n);
    int waited = 0;
    while (cmd_ready !== 1'b1 && waited < 10) begin
      @(negedge clock);
      waited++;
    end
    if (cmd_ready !== 1'b1) begin
      checks++; failures++;
      $display("[TB] FAIL send_ready_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; step_count = n;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_halted();
    int waited = 0;
    while (state !== 2'b00 && waited < 300) begin
      @(negedge clock);
      waited++;
    end
    if (state !== 2'b00) begin
      checks++; failures++;
      $display("[TB] FAIL halt_timeout: state=%0d required 0", state);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3;
    checks++; if (cpu_enable !== 1'b0) begin failures++; $display("[TB] FAIL rst_en_in: got %b need 0", cpu_enable); end
    checks++; if (state !== 2'b00) begin failures++; $display("[TB] FAIL rst_state_in: got %0d need 0", state); end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++; if (state !== 2'b00) begin failures++; $display("[TB] FAIL rst_state: got %0d need 0", state); end
    checks++; if (halt_cause !== 2'b00) begin failures++; $display("[TB] FAIL rst_cause: got %0d need 0", halt_cause); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_ready: got %b need 1", cmd_ready); end
    checks++; if (cmd_error !== 1'b0) begin failures++; $display("[TB] FAIL rst_error: got %b need 0", cmd_error); end
    checks++; if (cycle_count !== 32'd0) begin failures++; $display("[TB] FAIL rst_cycles: got %0d need 0", cycle_count); end
    checks++; if (retired_count !== 32'd0) begin failures++; $display("[TB] FAIL rst_retired: got %0d need 0", retired_count); end
    checks++; if (w_state !== 2'b00) begin failures++; $display("[TB] FAIL rst_w_state: got %0d need 0", w_state); end
  endtask

  task automatic test_ebreak_run();
    fill_prog();
    prog[3] = EBREAK;
    bp_enable = 1'b0;
    load_pc(32'd0);
    send(OP_CLEAR, 16'd0);
    send(OP_RUN, 16'd0);
    wait_halted();
    checks++; if (halt_cause !== 2'b11) begin failures++; $display("[TB] FAIL ebrk_cause: got %0d need 3", halt_cause); end
    checks++; if (retired_count !== 32'd3) begin failures++; $display("[TB] FAIL ebrk_retired: got %0d need 3", retired_count); end
    checks++; if (cycle_count !== 32'd4) begin failures++; $display("[TB] FAIL ebrk_cycles: got %0d need 4", cycle_count); end
    checks++; if (pc !== 32'd12) begin failures++; $display("[TB] FAIL ebrk_pc: got %0h need c", pc); end
    checks++; if (cpu_enable !== 1'b0) begin failures++; $display("[TB] FAIL ebrk_en: got %b need 0", cpu_enable); end
    send(OP_HALT, 16'd0);
    checks++; if (halt_cause !== 2'b00) begin failures++; $display("[TB] FAIL halted_halt_cause: got %0d need 0", halt_cause); end
    checks++; if (state !== 2'b00) begin failures++; $display("[TB] FAIL halted_halt_state: got %0d need 0", state); end
  endtask

  task automatic test_breakpoint();
    fill_prog();
    bp_enable = 1'b1;
    bp_address = 32'h8;
    load_pc(32'd0);
    send(OP_CLEAR, 16'd0);
    send(OP_RUN, 16'd0);
    wait_halted();
    checks++; if (pc !== 32'h8) begin failures++; $display("[TB] FAIL bp_pc: got %0h need 8", pc); end
    checks++; if (halt_cause !== 2'b10) begin failures++; $display("[TB] FAIL bp_cause: got %0d need 2", halt_cause); end
    checks++; if (retired_count !== 32'd2) begin failures++; $display("[TB] FAIL bp_retired: got %0d need 2", retired_count); end
    checks++; if (cycle_count !== 32'd3) begin failures++; $display("[TB] FAIL bp_cycles: got %0d need 3", cycle_count); end
    // resuming commits the breakpointed instruction and runs on to the ebreak at 0xfc
    send(OP_CLEAR, 16'd0);
    send(OP_RUN, 16'd0);
    wait_halted();
    checks++; if (pc !== 32'hfc) begin failures++; $display("[TB] FAIL bp_resume_pc: got %0h need fc", pc); end
    checks++; if (halt_cause !== 2'b11) begin failures++; $display("[TB] FAIL bp_resume_cause: got %0d need 3", halt_cause); end
    checks++; if (retired_count !== 32'd61) begin failures++; $display("[TB] FAIL bp_resume_retired: got %0d need 61", retired_count); end
    checks++; if (cycle_count !== 32'd62) begin failures++; $display("[TB] FAIL bp_resume_cycles: got %0d need 62", cycle_count); end
    bp_enable = 1'b0;
  endtask

  task automatic test_step();
    fill_prog();
    bp_enable = 1'b0;
    load_pc(32'd0);
    send(OP_CLEAR, 16'd0);
    send(OP_STEP, 16'd3);
    wait_halted();
    checks++; if (retired_count !== 32'd3) begin failures++; $display("[TB] FAIL step3_retired: got %0d need 3", retired_count); end
    checks++; if (pc !== 32'd12) begin failures++; $display("[TB] FAIL step3_pc: got %0h need c", pc); end
    checks++; if (halt_cause !== 2'b01) begin failures++; $display("[TB] FAIL step3_cause: got %0d need 1", halt_cause); end
    checks++; if (cycle_count !== 32'd3) begin failures++; $display("[TB] FAIL step3_cycles: got %0d need 3", cycle_count); end
    send(OP_CLEAR, 16'd0);
    send(OP_STEP, 16'd0);
    wait_halted();
    checks++; if (retired_count !== 32'd1) begin failures++; $display("[TB] FAIL step0_retired: got %0d need 1", retired_count); end
    checks++; if (pc !== 32'd16) begin failures++; $display("[TB] FAIL step0_pc: got %0h need 10", pc); end
    checks++; if (halt_cause !== 2'b01) begin failures++; $display("[TB] FAIL step0_cause: got %0d need 1", halt_cause); end
  endtask

  task automatic test_halt_cmd();
    int waited;
    int r0;
    int gap;
    // HALT lands on the same edge as a breakpoint: breakpoint cause wins
    fill_prog();
    bp_enable = 1'b1;
    bp_address = 32'h18;
    load_pc(32'h10);
    send(OP_CLEAR, 16'd0);
    send(OP_RUN, 16'd0);
    waited = 0;
    while (pc !== 32'h18 && waited < 20) begin @(negedge clock); waited++; end
    checks++; if (pc !== 32'h18) begin failures++; $display("[TB] FAIL race_reach_bp: pc=%0h need 18", pc); end
    cmd_valid = 1'b1; cmd_op = OP_HALT;
    @(negedge clock);
    cmd_valid = 1'b0;
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("[TB] FAIL race_ready_low: got %b need 0", cmd_ready); end
    wait_halted();
    checks++; if (halt_cause !== 2'b10) begin failures++; $display("[TB] FAIL race_cause: got %0d need 2", halt_cause); end
    checks++; if (retired_count !== 32'd2) begin failures++; $display("[TB] FAIL race_retired: got %0d need 2", retired_count); end
    // HALT in plain RUN: the accepting cycle still commits
    bp_enable = 1'b0;
    load_pc(32'd0);
    send(OP_CLEAR, 16'd0);
    send(OP_RUN, 16'd0);
    gap = $urandom_range(2, 6);
    repeat (gap) @(negedge clock);
    r0 = retired_count;
    cmd_valid = 1'b1; cmd_op = OP_HALT;
    @(negedge clock);
    cmd_valid = 1'b0;
    checks++; if (state !== 2'b00) begin failures++; $display("[TB] FAIL halt_state: got %0d need 0", state); end
    checks++; if (halt_cause !== 2'b00) begin failures++; $display("[TB] FAIL halt_cause: got %0d need 0", halt_cause); end
    checks++; if (retired_count !== 32'(r0 + 1)) begin failures++; $display("[TB] FAIL halt_retired: got %0d need %0d", retired_count, r0 + 1); end
    checks++; if (pc !== 32'(4 * (r0 + 1))) begin failures++; $display("[TB] FAIL halt_pc: got %0h need %0h", pc, 4 * (r0 + 1)); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("[TB] FAIL halt_ready_low: got %b need 0", cmd_ready); end
    @(negedge clock);
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL halt_ready_back: got %b need 1", cmd_ready); end
  endtask

  task automatic test_cmd_error_clear();
    fill_prog();
    bp_enable = 1'b0;
    load_pc(32'd0);
    send(OP_RUN, 16'd0);
    repeat (3) @(negedge clock);
    send(OP_RUN, 16'd0);
    checks++; if (cmd_error !== 1'b1) begin failures++; $display("[TB] FAIL err_pulse: got %b need 1", cmd_error); end
    checks++; if (state !== 2'b01) begin failures++; $display("[TB] FAIL err_state: got %0d need 1", state); end
    @(negedge clock);
    checks++; if (cmd_error !== 1'b0) begin failures++; $display("[TB] FAIL err_once: got %b need 0", cmd_error); end
    send(OP_CLEAR, 16'd0);
    checks++; if (cycle_count !== 32'd0) begin failures++; $display("[TB] FAIL clr_cycles: got %0d need 0", cycle_count); end
    checks++; if (retired_count !== 32'd0) begin failures++; $display("[TB] FAIL clr_retired: got %0d need 0", retired_count); end
    checks++; if (state !== 2'b01) begin failures++; $display("[TB] FAIL clr_state: got %0d need 1", state); end
    @(negedge clock);
    checks++; if (cycle_count !== 32'd1) begin failures++; $display("[TB] FAIL clr_cycles_next: got %0d need 1", cycle_count); end
    checks++; if (retired_count !== 32'd1) begin failures++; $display("[TB] FAIL clr_retired_next: got %0d need 1", retired_count); end
    send(OP_HALT, 16'd0);
    wait_halted();
  endtask

  task automatic test_wrap();
    fill_prog();
    bp_enable = 1'b0;
    load_pc(32'd0);
    send(OP_CLEAR, 16'd0);
    send(OP_STEP, 16'd15);
    wait_halted();
    checks++; if (w_retired !== 4'hf) begin failures++; $display("[TB] FAIL wrap_pre: got %0h need f", w_retired); end
    send(OP_STEP, 16'd1);
    wait_halted();
    checks++; if (w_retired !== 4'h0) begin failures++; $display("[TB] FAIL wrap_retired: got %0h need 0", w_retired); end
    checks++; if (w_cycle !== 4'h0) begin failures++; $display("[TB] FAIL wrap_cycles: got %0h need 0", w_cycle); end
    checks++; if (retired_count !== 32'd16) begin failures++; $display("[TB] FAIL wide_retired: got %0d need 16", retired_count); end
  endtask

  task automatic test_reset_midrun();
    fill_prog();
    load_pc(32'd0);
    send(OP_RUN, 16'd0);
    repeat (3) @(negedge clock);
    checks++; if (cpu_enable !== 1'b1) begin failures++; $display("[TB] FAIL midrun_en_before: got %b need 1", cpu_enable); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (cpu_enable !== 1'b0) begin failures++; $display("[TB] FAIL midrun_en: got %b need 0", cpu_enable); end
    checks++; if (state !== 2'b00) begin failures++; $display("[TB] FAIL midrun_state: got %0d need 0", state); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL midrun_ready: got %b need 1", cmd_ready); end
    checks++; if (cycle_count !== 32'd0 || retired_count !== 32'd0) begin failures++; $display("[TB] FAIL midrun_counts: got %0d/%0d need 0/0", cycle_count, retired_count); end
    checks++; if (halt_cause !== 2'b00 || cmd_error !== 1'b0) begin failures++; $display("[TB] FAIL midrun_cause_err: got %0d/%b need 0/0", halt_cause, cmd_error); end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_random();
    int commits, cycles;
    logic [1:0] cause;
    logic [31:0] start;
    bit is_step;
    int n;
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < 63; i++) prog[i] = ($urandom_range(0, 9) == 0) ? EBREAK : NOP;
      prog[63] = EBREAK;
      bp_enable  = 1'($urandom_range(0, 1));
      bp_address = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      start      = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      is_step    = 1'($urandom_range(0, 1));
      n          = $urandom_range(0, 9);
      load_pc(start);
      send(OP_CLEAR, 16'd0);
      predict(start, is_step, n, commits, cycles, cause);
      send(is_step ? OP_STEP : OP_RUN, 16'(n));
      wait_halted();
      checks++; if (halt_cause !== cause) begin failures++; $display("[TB] FAIL rnd%0d_cause: got %0d need %0d", it, halt_cause, cause); end
      checks++; if (retired_count !== 32'(commits)) begin failures++; $display("[TB] FAIL rnd%0d_retired: got %0d need %0d", it, retired_count, commits); end
      checks++; if (cycle_count !== 32'(cycles)) begin failures++; $display("[TB] FAIL rnd%0d_cycles: got %0d need %0d", it, cycle_count, cycles); end
      checks++; if (pc !== start + 32'(4 * commits)) begin failures++; $display("[TB] FAIL rnd%0d_pc: got %0h need %0h", it, pc, start + 32'(4 * commits)); end
      checks++; if (w_retired !== 4'(commits)) begin failures++; $display("[TB] FAIL rnd%0d_w_retired: got %0h need %0h", it, w_retired, 4'(commits)); end
    end
    bp_enable = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'b00; step_count = 16'd0;
    bp_enable = 1'b0; bp_address = 32'd0;
    pc_load = 1'b0; pc_load_val = 32'd0;
    fill_prog();
    test_reset();
    test_ebreak_run();
    test_breakpoint();
    test_step();
    test_halt_cmd();
    test_cmd_error_clear();
    test_wrap();
    test_reset_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
